// File: rtl/wb_master_seq.sv
// ---------------------------------------------------------------------------
// wb_master_seq
//   Single-outstanding Wishbone classic master. It turns a valid/ready command
//   stream into exactly one WB transaction at a time. The read data and the
//   status come back on a valid/ready response stream.
//
//   Handshakes: a transfer happens on a rising clock edge where valid and
//   ready are both 1. A producer holds valid and its payload steady until
//   that edge. The module never waits for the consumer before it raises
//   valid or ready.
//
//   Optional feature (macro WB_MASTER_TIMEOUT_EN):
//     When defined, a bus cycle that sees no ack/err within TIMEOUT_CYCLES
//     BUS cycles is ended. It then reports rsp_err_o=1 and rsp_tmo_o=1.
//     When undefined, BUS waits indefinitely and rsp_tmo_o is tied to 0.
//
// Ports
//   wb_clk_i, wb_rst_ni       clock, synchronous active-low reset
//   cmd_valid_i/cmd_ready_o   command handshake
//   cmd_we_i/sel_i/adr_i/dat_i command payload
//   rsp_valid_o/rsp_ready_i   response handshake
//   rsp_dat_o                 read data (0 for writes)
//   rsp_err_o, rsp_tmo_o      slave error or timeout, timeout flag
//   wbm_*                     Wishbone master signals
//   busy_o                    FSM not idle
// ---------------------------------------------------------------------------
module wb_master_seq #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [DATA_W/8-1:0] cmd_sel_i,
  input  logic [ADDR_W-1:0]   cmd_adr_i,
  input  logic [DATA_W-1:0]   cmd_dat_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_dat_o,
  output logic                rsp_err_o,
  output logic                rsp_tmo_o,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [DATA_W/8-1:0] wbm_sel_o,
  output logic [ADDR_W-1:0]   wbm_adr_o,
  output logic [DATA_W-1:0]   wbm_dat_o,
  input  logic [DATA_W-1:0]   wbm_dat_i,
  input  logic                wbm_ack_i,
  input  logic                wbm_err_i,
  output logic                busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t state;

  // The timeout counter is 16 bits wide, so the limit must fit in that range.
  if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("wb_master_seq: TIMEOUT_CYCLES out of range 2..65535");
  end

`ifdef WB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt;
`else
  assign rsp_tmo_o = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state       <= ST_IDLE;
      cmd_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      busy_o      <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
      rsp_tmo_o   <= 1'b0;
      tmo_cnt     <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          // cmd_ready_o is always 1 here, so valid alone completes the handshake.
          if (cmd_valid_i) begin
            wbm_we_o    <= cmd_we_i;
            wbm_sel_o   <= cmd_sel_i;
            wbm_adr_o   <= cmd_adr_i;
            wbm_dat_o   <= cmd_dat_i;
            wbm_cyc_o   <= 1'b1;
            wbm_stb_o   <= 1'b1;
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            state       <= ST_BUS;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
          end
        end

        ST_BUS: begin
          if (wbm_ack_i || wbm_err_i) begin
            // ack takes priority over err when both arrive together.
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_dat_o   <= wbm_we_o ? '0 : wbm_dat_i;
            rsp_err_o   <= wbm_err_i & ~wbm_ack_i;
            rsp_valid_o <= 1'b1;
            state       <= ST_RESP;
`ifdef WB_MASTER_TIMEOUT_EN
            rsp_tmo_o   <= 1'b0;
`endif
          end
`ifdef WB_MASTER_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b1;
            rsp_tmo_o   <= 1'b1;
            rsp_valid_o <= 1'b1;
            state       <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
`endif
        end

        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            state       <= ST_IDLE;
          end
        end

        default: begin
          state       <= ST_IDLE;
          cmd_ready_o <= 1'b1;
          rsp_valid_o <= 1'b0;
          wbm_cyc_o   <= 1'b0;
          wbm_stb_o   <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_seq.sv
// ---------------------------------------------------------------------------
// tb_wb_master_seq
//   Directed bench for wb_master_seq. Inputs change and outputs are sampled
//   on the falling clock edge, away from the active rising edge.
//   Expected response data sits in exp_q and is popped when each response is
//   checked.
// ---------------------------------------------------------------------------
module tb_wb_master_seq;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, cmd_we;
  logic [DW/8-1:0] cmd_sel;
  logic [AW-1:0] cmd_adr;
  logic [DW-1:0] cmd_dat;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_tmo;
  logic [DW-1:0] rsp_dat;
  logic          cyc, stb, we;
  logic [DW/8-1:0] sel;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_o, dat_i;
  logic          ack, err, busy;

  wb_master_seq #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_sel_i(cmd_sel), .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err), .rsp_tmo_o(rsp_tmo),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i),
    .wbm_ack_i(ack), .wbm_err_i(err), .busy_o(busy)
  );

  // scoreboard
  logic [DW-1:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // driver: present a command (taken at the next rising edge while idle)
  task automatic drive_cmd(input logic w, input logic [3:0] s,
                           input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_we    = w;
    cmd_sel   = s;
    cmd_adr   = a;
    cmd_dat   = d;
  endtask

  task automatic check_rsp(input string tag, input logic exp_err, input logic exp_tmo);
    logic [DW-1:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, "_dat"},   rsp_dat, e);
    check({tag, "_err"},   {31'd0, rsp_err}, {31'd0, exp_err});
    check({tag, "_tmo"},   {31'd0, rsp_tmo}, {31'd0, exp_tmo});
    check({tag, "_stb"},   {31'd0, stb}, 32'd0);
    check({tag, "_cyc"},   {31'd0, cyc}, 32'd0);
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, "_done_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_done_ready"}, {31'd0, cmd_ready}, 32'd1);
    check({tag, "_done_busy"},  {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_sel = '0;
    cmd_adr = '0; cmd_dat = '0; rsp_ready = 1'b0;
    dat_i = '0; ack = 1'b0; err = 1'b0;

    // reset state
    step(); step();
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_cyc",       {31'd0, cyc}, 32'd0);
    check("rst_stb",       {31'd0, stb}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_busy",      {31'd0, busy}, 32'd0);
    check("rst_adr",       adr, 32'd0);
    rst_n = 1'b1;
    step();

    // 1: zero-wait write
    drive_cmd(1'b1, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF);
    exp_q.push_back(32'h0);
    step();
    cmd_valid = 1'b0;
    check("wr_stb", {31'd0, stb}, 32'd1);
    check("wr_cyc", {31'd0, cyc}, 32'd1);
    check("wr_we",  {31'd0, we}, 32'd1);
    check("wr_adr", adr, 32'h3000_0004);
    check("wr_dat", dat_o, 32'hDEAD_BEEF);
    check("wr_sel", {28'd0, sel}, 32'hF);
    check("wr_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("wr_busy", {31'd0, busy}, 32'd1);
    ack = 1'b1;
    dat_i = 32'hFFFF_FFFF;   // must not leak into a write response
    step();
    ack = 1'b0;
    check_rsp("wr", 1'b0, 1'b0);
    finish_rsp("wr");
    check("wr_adr_retained", adr, 32'h3000_0004);

    // 2: read with three wait states, then 4: response back-pressure
    drive_cmd(1'b0, 4'hF, 32'h3000_0010, 32'h0);
    exp_q.push_back(32'h1234_5678);
    step();
    cmd_valid = 1'b0;
    check("rd_we", {31'd0, we}, 32'd0);
    check("rd_adr", adr, 32'h3000_0010);
    for (int i = 0; i < 3; i++) begin
      check("rd_wait_stb", {31'd0, stb}, 32'd1);
      check("rd_wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      step();
    end
    check("rd_last_wait_stb", {31'd0, stb}, 32'd1);
    ack = 1'b1;
    dat_i = 32'h1234_5678;
    step();
    ack = 1'b0;
    dat_i = 32'h5555_AAAA;
    exp_q.push_front(32'h1234_5678);
    check_rsp("rd", 1'b0, 1'b0);
    // hold the response while a new read command waits
    drive_cmd(1'b0, 4'hF, 32'h3000_0020, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rsp_dat",   rsp_dat, 32'h1234_5678);
      check("hold_stb",       {31'd0, stb}, 32'd0);
    end
    void'(exp_q.pop_front());
    finish_rsp("rd");
    // the waiting command is taken on the edge after the handshake

    // 3: slave error on that read
    exp_q.push_back(32'hA5A5_0000);
    step();
    cmd_valid = 1'b0;
    check("err_stb", {31'd0, stb}, 32'd1);
    check("err_adr", adr, 32'h3000_0020);
    err = 1'b1;
    dat_i = 32'hA5A5_0000;
    step();
    err = 1'b0;
    check_rsp("err", 1'b1, 1'b0);
    finish_rsp("err");

    // 3b: ack and err together count as ack
    drive_cmd(1'b0, 4'h3, 32'h3000_0030, 32'h0);
    exp_q.push_back(32'h0BAD_F00D);
    step();
    cmd_valid = 1'b0;
    check("ackerr_sel", {28'd0, sel}, 32'h3);
    ack = 1'b1; err = 1'b1;
    dat_i = 32'h0BAD_F00D;
    step();
    ack = 1'b0; err = 1'b0;
    check_rsp("ackerr", 1'b0, 1'b0);
    finish_rsp("ackerr");

    // 5: no ack
    drive_cmd(1'b1, 4'hF, 32'h3000_0040, 32'hCAFE_0001);
    step();
    cmd_valid = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
    exp_q.push_back(32'h0);
    for (int i = 1; i < TMO; i++) begin
      step();
      check("tmo_stb_held", {31'd0, stb}, 32'd1);
    end
    step();
    check_rsp("tmo", 1'b1, 1'b1);
    finish_rsp("tmo");
`else
    for (int i = 0; i < 20; i++) begin
      step();
      check("notmo_stb_held", {31'd0, stb}, 32'd1);
      check("notmo_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    end
    exp_q.push_back(32'h0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check_rsp("notmo", 1'b0, 1'b0);
    finish_rsp("notmo");
`endif

    // 6: reset in the middle of a bus cycle
    drive_cmd(1'b0, 4'hF, 32'h3000_0050, 32'h0);
    step();
    cmd_valid = 1'b0;
    check("mid_stb", {31'd0, stb}, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_cyc", {31'd0, cyc}, 32'd0);
    check("mid_rst_stb", {31'd0, stb}, 32'd0);
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    // a stray ack while idle must be ignored
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    check("idle_ack_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("idle_ack_busy", {31'd0, busy}, 32'd0);
    check("idle_ack_cyc", {31'd0, cyc}, 32'd0);
    check("idle_ack_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
